// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - in-order register writeback queue with optional read forwarding
//
// Buffers writeback requests (for example multiplier results) in front of a
// single register-file write port. Entries are drained strictly in order, at
// most one per cycle, whenever the write port is not stalled.
//
// Build option: WB_FORWARD_EN
//   defined   -> the three read addresses are compared against all pending
//                entries; the youngest match supplies fwd_data_k.
//   undefined -> no comparators are built; fwd_hit_* and fwd_data_* are 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   push_valid/address/data  producer request; accepted when push_ready=1
//   push_ready               !full && !rst && !flush
//   flush                    drop all pending entries at the edge
//   rf_stall                 register file write port busy this cycle
//   write_address/data/enable  head entry presented to the register file
//   in_address_1..3          read addresses seen by the register file
//   fwd_hit_1..3, fwd_data_1..3  forwarding result per read address
//   count                    number of pending entries
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [AW-1:0]              push_address,
    input  logic [DW-1:0]              push_data,
    output logic                       push_ready,
    input  logic                       flush,
    input  logic                       rf_stall,
    output logic [AW-1:0]              write_address,
    output logic [DW-1:0]              write_data,
    output logic                       write_enable,
    input  logic [AW-1:0]              in_address_1,
    input  logic [AW-1:0]              in_address_2,
    input  logic [AW-1:0]              in_address_3,
    output logic                       fwd_hit_1,
    output logic                       fwd_hit_2,
    output logic                       fwd_hit_3,
    output logic [DW-1:0]              fwd_data_1,
    output logic [DW-1:0]              fwd_data_2,
    output logic [DW-1:0]              fwd_data_3,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_d [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [DW-1:0] data_mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full, empty, push_fire;

    always_comb begin
        full          = (count_q == CW'(DEPTH));
        empty         = (count_q == '0);
        // A drain in the same cycle never frees a slot for a push when full.
        push_ready    = !full && !rst && !flush;
        push_fire     = push_valid && push_ready;
        write_enable  = !empty && !rf_stall;
        write_address = empty ? '0 : addr_mem_q[rd_ptr_q];
        write_data    = empty ? '0 : data_mem_q[rd_ptr_q];
        count         = count_q;

        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        if (push_fire) begin
            addr_mem_d[wr_ptr_q] = push_address;
            data_mem_d[wr_ptr_q] = push_data;
        end

        wr_ptr_d = wr_ptr_q + PW'(push_fire);
        rd_ptr_d = rd_ptr_q + PW'(write_enable);
        count_d  = count_q + CW'(push_fire) - CW'(write_enable);

        // The head is still written this cycle; only the bookkeeping is cleared.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

`ifdef WB_FORWARD_EN
    logic [AW-1:0] rd_addr [3];
    logic          hit     [3];
    logic [DW-1:0] hit_data[3];
    logic [PW-1:0] idx;

    // Walk entries from oldest to youngest so the last match wins. Only
    // registered storage is examined, so a push this cycle is not visible.
    always_comb begin
        rd_addr[0] = in_address_1;
        rd_addr[1] = in_address_2;
        rd_addr[2] = in_address_3;
        idx        = '0;
        for (int k = 0; k < 3; k++) begin
            hit[k]      = 1'b0;
            hit_data[k] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PW'(i);
                if ((CW'(i) < count_q) && (addr_mem_q[idx] == rd_addr[k])) begin
                    hit[k]      = 1'b1;
                    hit_data[k] = data_mem_q[idx];
                end
            end
        end
        fwd_hit_1  = hit[0];
        fwd_hit_2  = hit[1];
        fwd_hit_3  = hit[2];
        fwd_data_1 = hit_data[0];
        fwd_data_2 = hit_data[1];
        fwd_data_3 = hit_data[2];
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{in_address_1, in_address_2, in_address_3};
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_hit_3  = 1'b0;
    assign fwd_data_1 = '0;
    assign fwd_data_2 = '0;
    assign fwd_data_3 = '0;
`endif

    // Storage has no reset; empty/valid is tracked by count alone.
    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - directed self-checking bench for reg_wb_queue
module tb_reg_wb_queue;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid = 1'b0;
    logic [3:0]  push_address = '0;
    logic [31:0] push_data = '0;
    logic        push_ready;
    logic        flush = 1'b0;
    logic        rf_stall = 1'b0;
    logic [3:0]  write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic [3:0]  in_address_1 = '0;
    logic [3:0]  in_address_2 = '0;
    logic [3:0]  in_address_3 = '0;
    logic        fwd_hit_1, fwd_hit_2, fwd_hit_3;
    logic [31:0] fwd_data_1, fwd_data_2, fwd_data_3;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    reg_wb_queue #(.DEPTH(4), .AW(4), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_address(push_address),
        .push_data(push_data), .push_ready(push_ready),
        .flush(flush), .rf_stall(rf_stall),
        .write_address(write_address), .write_data(write_data),
        .write_enable(write_enable),
        .in_address_1(in_address_1), .in_address_2(in_address_2),
        .in_address_3(in_address_3),
        .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2), .fwd_hit_3(fwd_hit_3),
        .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
        .fwd_data_3(fwd_data_3),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d);
        push_valid   = 1'b1;
        push_address = a;
        push_data    = d;
        tick();
    endtask

    initial begin
        #1;
        // reset
        tick();
        tick();
        #1;
        chk("rst_push_ready", push_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_wa", write_address, 0);
        chk("rst_fwd", fwd_hit_1, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", push_ready, 1);

        // single push, one-cycle latency
        push(4'd0, 32'h2);
        push_valid = 1'b0;
        #1;
        chk("lat_we", write_enable, 1);
        chk("lat_wa", write_address, 0);
        chk("lat_wd", write_data, 32'h2);
        tick();
        #1;
        chk("lat_count_after", count, 0);
        chk("lat_we_after", write_enable, 0);
        chk("lat_wd_empty", write_data, 0);

        // fill under stall, fifth push ignored, ordered drain
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) push(4'(i), 32'h11 * i);
        push_address = 4'd5;
        push_data    = 32'h55;
        #1;
        chk("full_count", count, 4);
        chk("full_ready", push_ready, 0);
        chk("full_we_stall", write_enable, 0);
        tick();
        #1;
        chk("full_count_hold", count, 4);
        push_valid = 1'b0;
        rf_stall   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_we", write_enable, 1);
            chk("drain_wa", write_address, i);
            chk("drain_wd", write_data, 32'h11 * i);
            tick();
        end
        #1;
        chk("drain_empty", count, 0);
        chk("drain_we_off", write_enable, 0);

        // forwarding: youngest match wins, new push invisible this cycle
        rf_stall     = 1'b1;
        in_address_1 = 4'd2;
        in_address_2 = 4'd5;
        in_address_3 = 4'd2;
        push(4'd2, 32'hA);
        push_address = 4'd2;
        push_data    = 32'hB;
        #1;
        chk("fwd_same_cycle", fwd_data_1, FWD ? 32'hA : 32'h0);
        tick();
        push_valid = 1'b0;
        #1;
        chk("fwd_hit_1", fwd_hit_1, FWD);
        chk("fwd_data_1", fwd_data_1, FWD ? 32'hB : 32'h0);
        chk("fwd_hit_2", fwd_hit_2, 0);
        chk("fwd_data_2", fwd_data_2, 0);
        chk("fwd_data_3", fwd_data_3, FWD ? 32'hB : 32'h0);
        rf_stall = 1'b0;
        #1;
        chk("dup_wa0", write_address, 2);
        chk("dup_wd0", write_data, 32'hA);
        tick();
        chk("dup_wd1", write_data, 32'hB);
        chk("fwd_head_hit", fwd_hit_1, FWD);
        tick();
        chk("dup_empty", count, 0);
        chk("fwd_empty_hit", fwd_hit_1, 0);

        // steady push+pop with wrap-around
        rf_stall = 1'b1;
        push(4'd6, 32'h100);
        push(4'd7, 32'h101);
        rf_stall = 1'b0;
        for (int j = 0; j < 10; j++) begin
            push_valid   = 1'b1;
            push_address = 4'(j);
            push_data    = 32'h200 + j;
            #1;
            chk("wrap_count", count, 2);
            chk("wrap_wd", write_data, (j < 2) ? (32'h100 + j) : (32'h200 + j - 2));
            tick();
        end
        push_valid = 1'b0;
        #1;
        chk("wrap_count_end", count, 2);
        chk("wrap_tail0", write_data, 32'h208);
        tick();
        chk("wrap_tail1", write_data, 32'h209);
        chk("wrap_tail1_wa", write_address, 9);
        tick();
        chk("wrap_empty", count, 0);

        // flush with a push offered
        rf_stall = 1'b1;
        for (int i = 1; i <= 3; i++) push(4'(i), 32'h30 + i);
        flush    = 1'b1;
        rf_stall = 1'b0;
        push_address = 4'd9;
        push_data    = 32'h99;
        #1;
        chk("flush_ready", push_ready, 0);
        chk("flush_we_head", write_enable, 1);
        chk("flush_wd_head", write_data, 32'h31);
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        #1;
        chk("flush_count", count, 0);
        chk("flush_we", write_enable, 0);

        // reset with entries pending
        rf_stall = 1'b1;
        push(4'd4, 32'h44);
        push(4'd5, 32'h45);
        push_valid = 1'b0;
        rst        = 1'b1;
        rf_stall   = 1'b0;
        #1;
        chk("rst_mid_ready", push_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_count", count, 0);
        chk("rst_mid_we", write_enable, 0);
        chk("rst_mid_wd", write_data, 0);
        tick();
        chk("rst_mid_we2", write_enable, 0);
        chk("rst_mid_ready2", push_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 DEPTH, 4, entry count; power of two, 2..16.
REQ-002 AW, 4, register address width (matches reg_sync write_address_*).
REQ-003 DW, 32, data width (matches reg_sync write_data_*).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 push_valid  input  1  producer offers a writeback request (e.g. multiplier result).
REQ-007 push_address  input  AW  destination register of the request.
REQ-008 push_data  input  DW  data of the request.
REQ-009 push_ready  output  1  queue accepts the request this cycle.
REQ-010 flush  input  1  discard all pending entries.
REQ-011 rf_stall  input  1  register file write port unavailable this cycle.
REQ-012 write_address  output  AW  to reg_sync write_address_N.
REQ-013 write_data  output  DW  to reg_sync write_data_N.
REQ-014 write_enable  output  1  to reg_sync write_enable_N.
REQ-015 in_address_1, in_address_2, in_address_3  input  AW each  read addresses presented to reg_sync.
REQ-016 fwd_hit_1..3  output  1 each  pending entry matches corresponding in_address.
REQ-017 fwd_data_1..3  output  DW each  data of newest matching pending entry.
REQ-018 count  output  clog2(DEPTH)+1  number of pending entries.

Function
REQ-019 Queue SHALL be in-order FIFO; entry accepted when push_valid && push_ready at rising edge.
REQ-020 push_ready SHALL equal !full && !rst && !flush; no pass-through when full, even if a drain occurs the same cycle.
REQ-021 write_enable SHALL equal !empty && !rf_stall, combinational; write_address/write_data SHALL show head entry whenever !empty, zero when empty.
REQ-022 Head entry SHALL be popped at the rising edge where write_enable=1; one entry drained per cycle maximum.
REQ-023 Latency: entry accepted at edge N SHALL appear on write port in cycle N+1 (first cycle after edge N) if queue was empty and rf_stall=0.
REQ-024 Simultaneous push and pop SHALL both occur; count unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
REQ-026 push_valid while push_ready=0 SHALL be ignored; producer SHALL hold request until accepted.
REQ-027 Forwarding: fwd_hit_k SHALL be 1 iff any pending entry (head included, even while being written) has address == in_address_k; fwd_data_k SHALL be the youngest such entry's data, else 0.
REQ-028 Request accepted in the current cycle SHALL NOT be visible to forwarding until the following cycle.
REQ-029 Duplicate addresses SHALL be kept as separate entries and drained in order (no coalescing).
REQ-030 flush SHALL clear count and pointers at the edge; write_enable in the flush cycle SHALL still reflect current head; push in that cycle is dropped.

Reset
REQ-031 rst high at an edge SHALL set count=0, pointers=0; outputs thereafter: write_enable=0, write_address=0, write_data=0, fwd_hit_*=0, fwd_data_*=0, push_ready=0 while rst high, 1 the cycle after rst falls.
REQ-032 rst mid-operation SHALL discard all pending entries; no write is issued after the reset edge; entry storage contents are don't-care.
REQ-033 rst SHALL have priority over flush, push and pop.

Configuration
REQ-034 Macro WB_FORWARD_EN: defined -> forwarding logic per REQ-027/028 present.
REQ-035 WB_FORWARD_EN undefined -> no comparators built; fwd_hit_* and fwd_data_* tied to 0; all other behaviour identical.

Verification
REQ-036 Reset, push (addr 0, 0x00000002) -> next cycle write_enable=1, write_address=0, write_data=0x00000002; following cycle count=0, write_enable=0.
REQ-037 rf_stall=1, push addrs 1,2,3,4 (data 0x11..0x44) -> count=4, push_ready=0, 5th push ignored; release stall -> writes 1,2,3,4 in four consecutive cycles.
REQ-038 rf_stall=1, push (2,0xA), (2,0xB); in_address_1=2 -> fwd_hit_1=1, fwd_data_1=0xB; in_address_2=5 -> fwd_hit_2=0, fwd_data_2=0.
REQ-039 Queue holding 2 entries, push and drain same cycle for 10 cycles -> count stays 2, wrap-around preserves order.
REQ-040 Three entries pending, assert flush (with push_valid=1) -> next cycle count=0, write_enable=0; then assert rst with entries pending -> no writes after reset edge.
REQ-041 Build without WB_FORWARD_EN, repeat REQ-038 stimulus -> fwd_hit_*=0, drain order unchanged.
